// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump
//  Purpose  : Walks a register-file read port from first_addr to last_addr
//             (inclusive, wrapping modulo 2^ADDR_W) and presents each register
//             to a consumer over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] cur_q,      cur_d;
   logic [ADDR_W-1:0] last_q,     last_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   logic handshake;
   logic launch;
   logic abort_act;
   logic cur_is_last;

   // Qualified events shared by the next-state and datapath logic
   always_comb begin
      handshake   = (state_q == S_SEND) && out_ready;
      // start together with abort in IDLE must not launch a dump
      launch      = (state_q == S_IDLE) && start && !abort;
      abort_act   = (state_q != S_IDLE) && abort;
      cur_is_last = (cur_q == last_q);
   end

   // State register and datapath flops, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cur_q      <= '0;
         last_q     <= '0;
         rd_addr_q  <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         rd_addr_q  <= rd_addr_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

   // Next-state logic; abort overrides every transition, including a handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (launch) state_d = S_READ;
         S_READ:  state_d = S_SEND;
         S_SEND:  if (handshake) state_d = cur_is_last ? S_FIN : S_READ;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_act) state_d = S_IDLE;
   end

   // Datapath: rd_addr is loaded on the way into READ so it equals cur there
   always_comb begin
      cur_d      = cur_q;
      last_d     = last_q;
      rd_addr_d  = rd_addr_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (launch) begin
               cur_d     = first_addr;
               last_d    = last_addr;
               rd_addr_d = first_addr;
            end
         end
         S_READ: begin
            out_data_d = rd_data;
            out_addr_d = cur_q;
         end
         S_SEND: begin
            if (handshake && !abort && !cur_is_last) begin
               cur_d     = cur_q + ADDR_W'(1);
               rd_addr_d = cur_q + ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Status outputs decoded from the registered state
   always_comb begin
      out_valid = (state_q == S_SEND);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      rd_addr   = rd_addr_q;
      out_addr  = out_addr_q;
      out_data  = out_data_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump
//  Purpose  : Self-checking bench for reg_dump with a behavioural register file
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic        abort;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        busy;
   logic        done;

   logic [31:0] regs [32];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] first;
      logic [4:0] last;
      int         n;           // expected number of words
      logic [4:0] stall_addr;  // word address at which the consumer stalls
      int         stall;       // number of stall cycles
   } vec_t;

   reg_dump #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .abort      (abort),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done)
   );

   assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      return {27'd0, a} * 32'h11;
   endfunction

   task automatic run_dump(input vec_t v);
      int         n;
      int         stall_left;
      int         budget;
      logic       fin;
      logic [4:0] ea;
      n          = 0;
      stall_left = v.stall;
      fin        = 1'b0;
      budget     = 0;
      first_addr = v.first;
      last_addr  = v.last;
      out_ready  = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("read_busy", {31'd0, busy}, 32'd1);
      check("read_valid", {31'd0, out_valid}, 32'd0);
      check("read_rd_addr", {27'd0, rd_addr}, {27'd0, v.first});
      tick();
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      while (!fin && budget < 200) begin
         budget++;
         ea = v.first + n[4:0];
         if (out_valid) begin
            if (stall_left > 0 && ea == v.stall_addr) begin
               out_ready = 1'b0;
               check("stall_addr", {27'd0, out_addr}, {27'd0, ea});
               check("stall_data", out_data, exp_data(ea));
               stall_left--;
               tick();
            end else begin
               out_ready = 1'b1;
               check("word_addr", {27'd0, out_addr}, {27'd0, ea});
               check("word_data", out_data, exp_data(ea));
               n++;
               tick();
               if (n == v.n) begin
                  check("done_pulse", {31'd0, done}, 32'd1);
                  check("fin_valid", {31'd0, out_valid}, 32'd0);
                  tick();
                  check("after_busy", {31'd0, busy}, 32'd0);
                  check("after_done", {31'd0, done}, 32'd0);
                  fin = 1'b1;
               end else begin
                  check("gap_valid", {31'd0, out_valid}, 32'd0);
                  check("gap_done", {31'd0, done}, 32'd0);
                  check("gap_rd_addr", {27'd0, rd_addr}, {27'd0, 5'(v.first + n[4:0])});
               end
            end
         end else begin
            out_ready = 1'b1;
            tick();
         end
      end
      if (!fin) check("dump_timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t vecs [5];
      vecs[0] = '{5'd0,  5'd3,  4, 5'd0, 0};   // basic 0..3
      vecs[1] = '{5'd30, 5'd1,  4, 5'd0, 0};   // wrap 30,31,0,1
      vecs[2] = '{5'd0,  5'd3,  4, 5'd2, 5};   // consumer stalls 5 cycles on word 2
      vecs[3] = '{5'd7,  5'd7,  1, 5'd0, 0};   // single word
      vecs[4] = '{5'd10, 5'd12, 3, 5'd0, 0};   // mid-range walk

      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 17);
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      first_addr = 5'd0;
      last_addr  = 5'd0;
      out_ready  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
      check("rst_out_addr", {27'd0, out_addr}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table-driven dumps
      for (int i = 0; i < 5; i++) run_dump(vecs[i]);

      // start and abort together in IDLE stay idle; abort alone in IDLE is harmless
      first_addr = 5'd4;
      last_addr  = 5'd4;
      start      = 1'b1;
      abort      = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", {31'd0, busy}, 32'd0);
      tick();
      check("start_abort_idle2", {31'd0, busy}, 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", {31'd0, busy}, 32'd0);

      // Abort in SEND together with a handshake; second start ignored
      first_addr = 5'd0;
      last_addr  = 5'd3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("ab_valid0", {31'd0, out_valid}, 32'd1);
      first_addr = 5'd20;
      last_addr  = 5'd20;
      start      = 1'b1;
      out_ready  = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      check("ab_restart_ignored", {27'd0, rd_addr}, 32'd1);
      tick();
      check("ab_word1_addr", {27'd0, out_addr}, 32'd1);
      out_ready = 1'b1;
      abort     = 1'b1;
      tick();
      abort     = 1'b0;
      out_ready = 1'b0;
      check("ab_busy", {31'd0, busy}, 32'd0);
      check("ab_valid", {31'd0, out_valid}, 32'd0);
      check("ab_done", {31'd0, done}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ab_no_done", {31'd0, done}, 32'd0);
         check("ab_stay_idle", {31'd0, busy}, 32'd0);
      end

      // Write on the falling edge before capture is seen in the captured word
      first_addr = 5'd9;
      last_addr  = 5'd9;
      start      = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      regs[9] = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("wr_valid", {31'd0, out_valid}, 32'd1);
      check("wr_addr", {27'd0, out_addr}, 32'd9);
      check("wr_data", out_data, 32'hDEAD_BEEF);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("wr_done", {31'd0, done}, 32'd1);
      tick();
      check("wr_idle", {31'd0, busy}, 32'd0);
      regs[9] = 32'h99;

      // Asynchronous reset mid-dump
      first_addr = 5'd2;
      last_addr  = 5'd3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("mr_valid_pre", {31'd0, out_valid}, 32'd1);
      check("mr_data_pre", out_data, 32'h22);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_done", {31'd0, done}, 32'd0);
      check("mr_rd_addr", {27'd0, rd_addr}, 32'd0);
      check("mr_out_addr", {27'd0, out_addr}, 32'd0);
      check("mr_out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("mr_wait_idle", {31'd0, busy}, 32'd0);
      tick();
      check("mr_wait_idle2", {31'd0, out_valid}, 32'd0);
      run_dump('{5'd5, 5'd5, 1, 5'd0, 0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
